// File: rtl/projector_pkg.sv
// rtl/projector_pkg.sv - shared types, half-float constants and comparators for projector_stream
package projector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // World-space position as it travels through the input FIFO and into the transform.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } position_t;

    localparam int TRANSFORM_LATENCY = 4;

    localparam logic [15:0] F16_RADIUS_5    = 16'h4500;
    localparam logic [15:0] F16_NEAR_1      = 16'h3C00;
    localparam logic [15:0] F16_FAR_200     = 16'h5A40;
    localparam logic [15:0] F16_NEG_10      = 16'hC900;
    localparam logic [15:0] F16_X_MAX_360   = 16'h5DA0;
    localparam logic [15:0] F16_Y_MAX_200   = 16'h5A40;

    // Sign-magnitude less-than; +0 and -0 compare equal. NaN/Inf never reach here.
    function automatic logic f16_lt(input logic [15:0] a, input logic [15:0] b);
        logic a_zero;
        logic b_zero;
        logic lt;
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);
        if (a_zero && b_zero) begin
            lt = 1'b0;
        end else if (a[15] != b[15]) begin
            lt = a[15];
        end else if (!a[15]) begin
            lt = (a[14:0] < b[14:0]);
        end else begin
            lt = (a[14:0] > b[14:0]);
        end
        return lt;
    endfunction

    function automatic logic f16_gt(input logic [15:0] a, input logic [15:0] b);
        return f16_lt(b, a);
    endfunction

endpackage

// File: rtl/projector_fifo.sv
// rtl/projector_fifo.sv - synchronous FIFO with full/empty flags, no push bypass
module projector_fifo #(
    parameter int WIDTH = 58,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/transform_position.sv
// rtl/transform_position.sv - fixed-latency world-to-screen transform unit
module transform_position
    import projector_pkg::*;
#(
    parameter int LATENCY = TRANSFORM_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  position_t   pos,
    output logic        done,
    output logic [15:0] f_screen_x,
    output logic [15:0] f_screen_y,
    output logic [15:0] f_depth
);

    position_t          pipe [LATENCY];
    logic [LATENCY-1:0] busy;

    // Camera sits at the origin with unit scale, so screen x/y and depth map straight from x/y/z.
    assign done       = busy[LATENCY-1];
    assign f_screen_x = pipe[LATENCY-1].x;
    assign f_screen_y = pipe[LATENCY-1].y;
    assign f_depth    = pipe[LATENCY-1].z;

    // Valid token ripples alongside the data; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= {busy[LATENCY-2:0], start};
    end

    // Operand capture on start and data pipeline.
    always_ff @(posedge clk) begin
        pipe[0] <= pos;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end

endmodule

// File: rtl/projector_stream.sv
// rtl/projector_stream.sv - buffered particle projector with optional culling (PROJECTOR_CULL_EN)
module projector_stream
    import projector_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 8,
    parameter int          TAG_W         = 10,
    parameter logic [15:0] SPHERE_RADIUS = F16_RADIUS_5,
    parameter logic [15:0] NEAR_F        = F16_NEAR_1,
    parameter logic [15:0] FAR_F         = F16_FAR_200,
    parameter logic [15:0] X_MIN_F       = F16_NEG_10,
    parameter logic [15:0] X_MAX_F       = F16_X_MAX_360,
    parameter logic [15:0] Y_MIN_F       = F16_NEG_10,
    parameter logic [15:0] Y_MAX_F       = F16_Y_MAX_200
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [15:0]      f_x_in,
    input  logic [15:0]      f_y_in,
    input  logic [15:0]      f_z_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             data_valid_in,
    output logic             ready_out,
    output logic [15:0]      f_center_x_pos,
    output logic [15:0]      f_center_y_pos,
    output logic [15:0]      f_center_depth,
    output logic [15:0]      f_radius,
    output logic [TAG_W-1:0] tag_out,
    output logic             data_valid_out,
    input  logic             rasterizer_ready,
    output logic [31:0]      proj_count,
    output logic [31:0]      cull_count
);

    localparam int FIFO_W = $bits(position_t) + TAG_W;

    state_t            state;
    state_t            state_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_head;
    position_t         head_pos;
    logic [TAG_W-1:0]  head_tag;
    logic              start;
    logic              done;
    logic [15:0]       tr_x;
    logic [15:0]       tr_y;
    logic [15:0]       tr_depth;
    logic [TAG_W-1:0]  tag_q;
    logic [15:0]       res_x;
    logic [15:0]       res_y;
    logic [15:0]       res_depth;
    logic              capture_res;
    logic              load_out;
    logic              count_proj;
    logic              count_cull;
    logic              cull;

    assign ready_out             = !fifo_full;
    assign {head_pos, head_tag}  = fifo_head;
    assign data_valid_out        = (state == HOLD);

    projector_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (data_valid_in && ready_out),
        .push_data ({f_x_in, f_y_in, f_z_in, tag_in}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The transform's input stage doubles as the operand register, so the FIFO head feeds it directly.
    transform_position u_transform (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .start      (start),
        .pos        (head_pos),
        .done       (done),
        .f_screen_x (tr_x),
        .f_screen_y (tr_y),
        .f_depth    (tr_depth)
    );

`ifdef PROJECTOR_CULL_EN
    assign cull = f16_lt(res_depth, NEAR_F)  || f16_gt(res_depth, FAR_F)  ||
                  f16_lt(res_x,     X_MIN_F) || f16_gt(res_x,     X_MAX_F) ||
                  f16_lt(res_y,     Y_MIN_F) || f16_gt(res_y,     Y_MAX_F);

    // Culled-particle counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)       cull_count <= '0;
        else if (count_cull) cull_count <= cull_count + 32'd1;
    end
`else
    logic unused_cull_cfg;
    assign cull            = 1'b0;
    assign cull_count      = '0;
    assign unused_cull_cfg = ^{count_cull, NEAR_F, FAR_F, X_MIN_F, X_MAX_F, Y_MIN_F, Y_MAX_F};
`endif

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty)      state_next = WAIT;
            WAIT:  if (done)             state_next = CHECK;
            CHECK: state_next = cull ? IDLE : HOLD;
            HOLD:  if (rasterizer_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: pop/start strobes, capture and load enables, counter increments.
    always_comb begin
        fifo_pop    = 1'b0;
        start       = 1'b0;
        capture_res = 1'b0;
        load_out    = 1'b0;
        count_proj  = 1'b0;
        count_cull  = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
                start    = !fifo_empty;
            end
            WAIT:  capture_res = done;
            CHECK: begin
                count_cull = cull;
                load_out   = !cull;
            end
            HOLD:  count_proj = rasterizer_ready;
            default: ;
        endcase
    end

    // Datapath: tag at pop, result on done, output registers only on entry to HOLD.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tag_q          <= '0;
            res_x          <= '0;
            res_y          <= '0;
            res_depth      <= '0;
            f_center_x_pos <= '0;
            f_center_y_pos <= '0;
            f_center_depth <= '0;
            f_radius       <= '0;
            tag_out        <= '0;
        end else begin
            if (fifo_pop) tag_q <= head_tag;
            if (capture_res) begin
                res_x     <= tr_x;
                res_y     <= tr_y;
                res_depth <= tr_depth;
            end
            if (load_out) begin
                f_center_x_pos <= res_x;
                f_center_y_pos <= res_y;
                f_center_depth <= res_depth;
                f_radius       <= SPHERE_RADIUS;
                tag_out        <= tag_q;
            end
        end
    end

    // Emitted-particle counter, stepped on each output handshake.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)       proj_count <= '0;
        else if (count_proj) proj_count <= proj_count + 32'd1;
    end

endmodule

// File: tb/tb_projector_stream.sv
// tb/tb_projector_stream.sv - self-checking bench for projector_stream
module tb_projector_stream;

`ifdef PROJECTOR_CULL_EN
    localparam bit CULL_EN = 1'b1;
`else
    localparam bit CULL_EN = 1'b0;
`endif
    localparam int L = 4;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [9:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fx = '0, fy = '0, fz = '0;
    logic [9:0]  tag_i = '0;
    logic        dvin = 1'b0;
    logic        rdy = 1'b0;
    logic        ready_out, data_valid_out;
    logic [15:0] f_center_x_pos, f_center_y_pos, f_center_depth, f_radius;
    logic [9:0]  tag_out;
    logic [31:0] proj_count, cull_count;

    int   total = 0;
    int   bad = 0;
    int   hs = 0;
    int   cull_exp = 0;
    int   accepted = 0;
    ent_t exp_q[$];

    projector_stream dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .f_x_in           (fx),
        .f_y_in           (fy),
        .f_z_in           (fz),
        .tag_in           (tag_i),
        .data_valid_in    (dvin),
        .ready_out        (ready_out),
        .f_center_x_pos   (f_center_x_pos),
        .f_center_y_pos   (f_center_y_pos),
        .f_center_depth   (f_center_depth),
        .f_radius         (f_radius),
        .tag_out          (tag_out),
        .data_valid_out   (data_valid_out),
        .rasterizer_ready (rdy),
        .proj_count       (proj_count),
        .cull_count       (cull_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real v;
        e = int'(h[14:10]);
        v = (e == 0) ? real'(int'(h[9:0])) : real'(1024 + int'(h[9:0]));
        if (e == 0) e = 1;
        for (int i = 0; i < 25; i++) v = v / 2.0;
        for (int i = 0; i < e; i++)  v = v * 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic bit culled(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        real rx, ry, rz;
        rx = h2r(x);
        ry = h2r(y);
        rz = h2r(z);
        return (rz < 1.0) || (rz > 200.0) || (rx < -10.0) || (rx > 360.0) || (ry < -10.0) || (ry > 200.0);
    endfunction

    task automatic model_push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic [9:0] t);
        ent_t e;
        accepted++;
        if (CULL_EN && culled(x, y, z)) begin
            cull_exp++;
        end else begin
            e.x = x; e.y = y; e.z = z; e.tag = t;
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input logic [9:0] t);
        int budget = 0;
        bit acc = 1'b0;
        fx = x; fy = y; fz = z; tag_i = t; dvin = 1'b1;
        while (!acc && budget < 1000) begin
            acc = ready_out;
            @(posedge clk);
            budget++;
            if (!acc) @(negedge clk);
        end
        if (acc) model_push(x, y, z, t);
        else     chk("send_timeout", 32'(budget), 0);
        @(negedge clk);
        dvin = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 0);
        repeat (12) @(negedge clk);
    endtask

    // Every cycle: counter against observed handshakes, and any beat against the model queue head.
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (rst_n) begin
            chk("proj_count_track", proj_count, 32'(hs));
            if (data_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 32'(data_valid_out), 0);
                end else begin
                    e = exp_q[0];
                    chk("beat_x", 32'(f_center_x_pos), 32'(e.x));
                    chk("beat_y", 32'(f_center_y_pos), 32'(e.y));
                    chk("beat_depth", 32'(f_center_depth), 32'(e.z));
                    chk("beat_radius", 32'(f_radius), 32'h4500);
                    chk("beat_tag", 32'(tag_out), 32'(e.tag));
                    if (rdy) begin
                        e = exp_q.pop_front();
                        hs++;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        ent_t bnd [4];

        // Model pins: literal expectations for the half-float decode and cull rule.
        chk("pin_h2r_200", 32'(h2r(16'h5A40) == 200.0), 1);
        chk("pin_h2r_neg10", 32'(h2r(16'hC900) == -10.0), 1);
        chk("pin_xmax_ok", 32'(culled(16'h5DA0, 16'h3C00, 16'h4000)), 0);
        chk("pin_xmax_ulp", 32'(culled(16'h5DA1, 16'h3C00, 16'h4000)), 1);
        chk("pin_near_half", 32'(culled(16'h3C00, 16'h3C00, 16'h3800)), 1);
        chk("pin_negzero", 32'(culled(16'h3C00, 16'h8000, 16'h5A40)), 0);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(data_valid_out), 0);
        chk("rst_ready", 32'(ready_out), 1);
        chk("rst_x", 32'(f_center_x_pos), 0);
        chk("rst_tag", 32'(tag_out), 0);
        chk("rst_proj", proj_count, 0);
        chk("rst_cull", cull_count, 0);
        #3 rst_n = 1'b1;
        rdy = 1'b1;
        @(negedge clk);

        // Single particle: latency and literal beat contents.
        send(16'h3C00, 16'h4000, 16'h4900, 10'd5);
        k = 1;
        while (!data_valid_out && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("single_latency", 32'(k), 32'(3 + L));
        chk("single_tag", 32'(tag_out), 5);
        chk("single_radius", 32'(f_radius), 32'h4500);
        chk("single_depth", 32'(f_center_depth), 32'h4900);
        drain();
        chk("single_proj", proj_count, 1);

        // Burst of 12 against a stalled rasterizer.
        accepted = 0;
        rdy = 1'b0;
        fork
            begin
                repeat (40) @(negedge clk);
                chk("burst_accepted", 32'(accepted), 9);
                chk("burst_ready_low", 32'(ready_out), 0);
                repeat (160) @(negedge clk);
                rdy = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++)
                    send(16'h3C00 + 16'(i) * 16'h0100, 16'h4000 + 16'(i), 16'h4000 + 16'(i) * 16'h0100, 10'(20 + i));
            end
        join
        drain();
        chk("burst_proj", proj_count, 13);
        chk("burst_cull", cull_count, 32'(cull_exp));

        // Depth cull: 0.5 then 50.0.
        send(16'h3C00, 16'h4000, 16'h3800, 10'd1);
        send(16'h3C00, 16'h4000, 16'h5240, 10'd2);
        drain();
        chk("depth_cull_count", cull_count, CULL_EN ? 32'd1 : 32'd0);
        chk("depth_cull_proj", proj_count, CULL_EN ? 32'd14 : 32'd15);

        // Boundary limits: exact limits accepted, one ulp past X_MAX culled.
        bnd[0] = '{16'h5DA0, 16'h4000, 16'h4000, 10'd3};
        bnd[1] = '{16'h5DA1, 16'h4000, 16'h4000, 10'd4};
        bnd[2] = '{16'hC900, 16'h5A40, 16'h3C00, 10'd6};
        bnd[3] = '{16'h3C00, 16'h8000, 16'h5A40, 10'd7};
        for (int i = 0; i < 4; i++) send(bnd[i].x, bnd[i].y, bnd[i].z, bnd[i].tag);
        drain();
        chk("bound_cull", cull_count, CULL_EN ? 32'd2 : 32'd0);
        chk("bound_proj", proj_count, CULL_EN ? 32'd17 : 32'd19);
        chk("bound_cull_model", cull_count, 32'(cull_exp));

        // Reset while WAIT with three entries queued.
        for (int i = 0; i < 4; i++) send(16'h4000, 16'h4000, 16'h4200, 10'(40 + i));
        #3 rst_n = 1'b0;
        exp_q.delete();
        hs = 0;
        cull_exp = 0;
        #1;
        chk("midrst_valid", 32'(data_valid_out), 0);
        chk("midrst_ready", 32'(ready_out), 1);
        chk("midrst_x", 32'(f_center_x_pos), 0);
        chk("midrst_radius", 32'(f_radius), 0);
        chk("midrst_tag", 32'(tag_out), 0);
        chk("midrst_proj", proj_count, 0);
        chk("midrst_cull", cull_count, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_ready", 32'(ready_out), 1);
        chk("postrst_valid", 32'(data_valid_out), 0);
        chk("postrst_proj", proj_count, 0);

        // Rasterizer ready toggling every cycle during HOLD.
        rdy = 1'b0;
        fork
            begin
                repeat (80) begin
                    @(negedge clk);
                    rdy = ~rdy;
                end
                rdy = 1'b1;
            end
            begin
                send(16'h4400, 16'h4500, 16'h4600, 10'd100);
                send(16'h4800, 16'h4880, 16'h4900, 10'd101);
                send(16'hC000, 16'h3C00, 16'h5000, 10'd102);
            end
        join
        drain();
        chk("toggle_proj", proj_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
